ps2_rx_fifo: RTL and testbench

Parametrised next-generation PS/2 device-to-host receiver. Synchronises and deglitches the raw ps2_clk/ps2_data pins, then decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop). It checks parity and framing, recovers from stalled frames with a watchdog, and buffers good bytes in a FIFO drained over a valid/ready handshake. It sits between the keyboard pins and the 68k bus interface logic.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 49 ++++
 rtl/ps2_rx_fifo.sv | 164 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state type, constants and parity helper for the PS/2 receiver
// Purpose: common declarations imported by ps2_line_filter and ps2_rx_fifo.
// Ports: none (package).
package ps2_pkg;

   localparam int PS2_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   // True when data plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser plus glitch filter for one PS/2 pin
// Purpose: brings an asynchronous pin into the clk domain and only follows it
//          after FILTER_LEN consecutive synchronised samples disagree with the output.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset (output idles high)
//   line_in  in   raw asynchronous pin
//   line_out out  synchronised, deglitched line
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic line_out
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= '1;
         cnt      <= '0;
         line_out <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
         // Any sample agreeing with the output restarts the run of disagreeing samples.
         if (synced == line_out) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            line_out <= synced;
            cnt      <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host frame receiver with byte FIFO and sticky errors
// Purpose: filters the PS/2 pins, decodes start/8 data/odd parity/stop frames,
//          abandons stalled frames via a watchdog and queues good bytes.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   ps2_clk         raw PS/2 clock pin
//   ps2_data        raw PS/2 data pin
//   data            FIFO head byte (show-ahead)
//   data_valid      FIFO non-empty
//   data_ready      consumer takes the head byte when data_valid is high
//   fifo_count      bytes currently held
//   parity_err      sticky parity failure
//   frame_err       sticky bad stop bit or watchdog timeout
//   overflow        sticky good byte dropped on a full FIFO
//   clear_err       pulse clearing the three sticky flags
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    data,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          clear_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(PS2_DATA_BITS);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);

   logic clk_f, data_f, clk_prev, sample;

   ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk      (clk),
      .reset    (reset),
      .line_in  (ps2_clk),
      .line_out (clk_f)
   );

   ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk      (clk),
      .reset    (reset),
      .line_in  (ps2_data),
      .line_out (data_f)
   );

   // Sample point: filtered clock is low now but was high last cycle.
   assign sample = clk_prev & ~clk_f;

   ps2_state_t                 state;
   logic [BW-1:0]              bit_cnt;
   logic [PS2_DATA_BITS-1:0]   shreg;
   logic                       par_ok;
   logic [WW-1:0]              watchdog;
   logic                       frame_push, par_bad, stop_bad, timeout;

   assign frame_push = sample && (state == STOP) && data_f && par_ok;
   assign par_bad    = sample && (state == STOP) && data_f && !par_ok;
   assign stop_bad   = sample && (state == STOP) && !data_f;
   // A sample point in the same cycle always rescues the frame.
   assign timeout    = (state != IDLE) && !sample && (watchdog == WD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_ok   <= 1'b0;
         watchdog <= '0;
         clk_prev <= 1'b1;
      end else begin
         clk_prev <= clk_f;

         if (state == IDLE || sample || timeout)
            watchdog <= '0;
         else
            watchdog <= watchdog + WW'(1);

         if (timeout) begin
            state <= IDLE;
         end else if (sample) begin
            case (state)
               IDLE: begin
                  if (!data_f) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg[bit_cnt] <= data_f;
                  if (bit_cnt == BIT_LAST)
                     state <= PARITY;
                  else
                     bit_cnt <= bit_cnt + BW'(1);
               end
               PARITY: begin
                  par_ok <= odd_parity_ok(shreg, data_f);
                  state  <= STOP;
               end
               STOP:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, full, wr_en;

   assign data_valid = (fifo_count != '0);
   assign pop        = data_valid & data_ready;
   assign full       = (fifo_count == FULL_CNT);
   // A full FIFO still accepts a byte if the head leaves in the same cycle.
   assign wr_en      = frame_push & (~full | pop);
   assign data       = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !pop)
            fifo_count <= fifo_count + (AW + 1)'(1);
         else if (pop && !wr_en)
            fifo_count <= fifo_count - (AW + 1)'(1);
      end
   end

   // A new error in the same cycle as clear_err keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         parity_err <= par_bad | (parity_err & ~clear_err);
         frame_err  <= stop_bad | timeout | (frame_err & ~clear_err);
         overflow   <= (frame_push & full & ~pop) | (overflow & ~clear_err);
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard testbench for ps2_rx_fifo
module tb_ps2_rx_fifo;

   localparam int DEPTH = 4;
   localparam int H     = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       data_ready = 1'b0;
   logic       clear_err = 1'b0;
   logic [7:0] data;
   logic       data_valid;
   logic [2:0] fifo_count;
   logic       parity_err, frame_err, overflow;

   int         tests = 0;
   int         fails = 0;
   int         valid_cycles = 0;
   logic [7:0] exp_q[$];
   logic       exp_par = 1'b0, exp_frm = 1'b0, exp_ovf = 1'b0;
   bit         rand_ready = 1'b0;

   ps2_rx_fifo #(
      .SYNC_STAGES(2), .FILTER_LEN(4), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .data(data), .data_valid(data_valid), .data_ready(data_ready),
      .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
      .overflow(overflow), .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_parity_err"}, 32'(parity_err), 32'(exp_par));
      check({tag, "_frame_err"},  32'(frame_err),  32'(exp_frm));
      check({tag, "_overflow"},   32'(overflow),   32'(exp_ovf));
   endtask

   task automatic do_clear();
      clear_err = 1'b1;
      wait_cycles(1);
      clear_err = 1'b0;
      exp_par = 1'b0; exp_frm = 1'b0; exp_ovf = 1'b0;
      wait_cycles(1);
   endtask

   // action 1: pulse data_ready, action 2: pulse clear_err, both in the cycle
   // where the filtered clock falling edge is seen (pin edge + 6 clocks).
   task automatic ps2_bit(input logic b, input bit glitch, input int action);
      ps2_data = b;
      if (glitch) begin
         wait_cycles(8);
         ps2_clk = 1'b0;
         wait_cycles(3);
         ps2_clk = 1'b1;
         wait_cycles(H - 11);
      end else begin
         wait_cycles(H);
      end
      ps2_clk = 1'b0;
      if (action == 1) begin
         wait_cycles(6); data_ready = 1'b1; wait_cycles(1); data_ready = 1'b0; wait_cycles(H - 7);
      end else if (action == 2) begin
         wait_cycles(6); clear_err = 1'b1; wait_cycles(1); clear_err = 1'b0; wait_cycles(H - 7);
      end else begin
         wait_cycles(H);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                             input int action, input bit glitch);
      logic par;
      par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
      if (bad_par) par = ~par;
      ps2_bit(1'b0, glitch, 0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch, 0);
      ps2_bit(par, glitch, 0);
      if (!stop)                                    exp_frm = 1'b1;
      else if (bad_par)                             exp_par = 1'b1;
      else if (exp_q.size() < DEPTH || action == 1) exp_q.push_back(b);
      else                                          exp_ovf = 1'b1;
      ps2_bit(stop, glitch, action);
      ps2_data = 1'b1;
      wait_cycles(20);
   endtask

   // Monitor: every accepted head byte must match the oldest expected byte.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (data_valid === 1'b1) valid_cycles++;
         if (data_valid === 1'b1 && data_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_unexpected: got %0h expected no byte", data);
            end else begin
               e = exp_q.pop_front();
               check("pop_data", 32'(data), 32'(e));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) data_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [7:0] rb;
      bit         rp;
      logic       rs;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      wait_cycles(2);
      check("reset_data",       32'(data),       0);
      check("reset_data_valid", 32'(data_valid), 0);
      check("reset_fifo_count", 32'(fifo_count), 0);
      check_flags("reset");

      // single good byte
      data_ready = 1'b1;
      valid_cycles = 0;
      send_frame(8'h1C, 0, 1'b1, 0, 0);
      wait_cycles(10);
      check("single_valid_pulse", 32'(valid_cycles), 1);
      check("single_count", 32'(fifo_count), 0);
      check_flags("single");

      // parity error stays until cleared
      send_frame(8'hF0, 1, 1'b1, 0, 0);
      check_flags("parity");
      wait_cycles(100);
      check("parity_sticky", 32'(parity_err), 1);
      do_clear();
      check_flags("parity_clr");

      // bad stop bit
      send_frame(8'h5A, 0, 1'b0, 0, 0);
      check_flags("stop");
      check("stop_no_push", 32'(fifo_count), 0);
      do_clear();

      // watchdog: start bit plus three data bits, then the clock stalls
      ps2_bit(1'b0, 0, 0);
      ps2_bit(1'b1, 0, 0);
      ps2_bit(1'b0, 0, 0);
      ps2_bit(1'b1, 0, 0);
      ps2_data = 1'b1;
      wait_cycles(40);
      check("timeout_early", 32'(frame_err), 0);
      wait_cycles(90);
      exp_frm = 1'b1;
      check_flags("timeout");
      do_clear();
      send_frame(8'h1C, 0, 1'b1, 0, 0);
      wait_cycles(10);
      check_flags("after_timeout");
      check("after_timeout_count", 32'(fifo_count), 0);

      // overflow
      data_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b1, 0, 0);
      check("ovf_count", 32'(fifo_count), 32'(exp_q.size()));
      check("ovf_full", 32'(fifo_count), 4);
      check_flags("ovf");
      data_ready = 1'b1;
      wait_cycles(10);
      check("ovf_drained", 32'(fifo_count), 0);
      do_clear();

      // glitch rejection in idle (data low so a false edge would start a frame)
      ps2_data = 1'b0;
      repeat (5) begin
         ps2_clk = 1'b0; wait_cycles(2); ps2_clk = 1'b1; wait_cycles(10);
      end
      ps2_data = 1'b1;
      wait_cycles(200);
      check_flags("glitch_idle");
      check("glitch_idle_count", 32'(fifo_count), 0);
      send_frame(8'h1C, 0, 1'b1, 0, 1);
      wait_cycles(10);
      check_flags("glitch_frame");
      check("glitch_frame_count", 32'(fifo_count), 0);

      // push and pop together on a full FIFO
      data_ready = 1'b0;
      send_frame(8'h11, 0, 1'b1, 0, 0);
      send_frame(8'h22, 0, 1'b1, 0, 0);
      send_frame(8'h33, 0, 1'b1, 0, 0);
      send_frame(8'h44, 0, 1'b1, 0, 0);
      send_frame(8'h55, 0, 1'b1, 1, 0);
      check("simul_count", 32'(fifo_count), 4);
      check_flags("simul");
      data_ready = 1'b1;
      wait_cycles(10);
      check("simul_drained", 32'(fifo_count), 0);

      // clear_err in the same cycle as a new parity error
      send_frame(8'h3C, 1, 1'b1, 2, 0);
      check_flags("clear_vs_set");
      do_clear();

      // randomized frames with a random consumer
      rand_ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         rb = 8'($urandom);
         rp = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 7) != 0);
         send_frame(rb, rp, rs, 0, 0);
         wait_cycles(30);
         check_flags("rand");
         if (exp_par || exp_frm || exp_ovf) do_clear();
      end
      rand_ready = 1'b0;
      data_ready = 1'b1;
      wait_cycles(20);
      check("rand_drained", 32'(fifo_count), 32'(exp_q.size()));

      // reset with bytes queued and a frame in flight
      data_ready = 1'b0;
      send_frame(8'hA1, 0, 1'b1, 0, 0);
      send_frame(8'hA2, 0, 1'b1, 0, 0);
      ps2_bit(1'b0, 0, 0);
      ps2_bit(1'b1, 0, 0);
      ps2_data = 1'b1;
      reset = 1'b1;
      wait_cycles(3);
      reset = 1'b0;
      exp_q.delete();
      exp_par = 1'b0; exp_frm = 1'b0; exp_ovf = 1'b0;
      wait_cycles(2);
      check("rst_mid_count", 32'(fifo_count), 0);
      check("rst_mid_valid", 32'(data_valid), 0);
      check("rst_mid_data", 32'(data), 0);
      check_flags("rst_mid");
      data_ready = 1'b1;
      wait_cycles(20);
      send_frame(8'h1C, 0, 1'b1, 0, 0);
      wait_cycles(10);
      check_flags("after_rst");
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
